// File: rtl/hazard_scoreboard_pkg.sv
// Shared constants for the hazard scoreboard: record field widths, default latencies, forward-select encoding.
package hazard_scoreboard_pkg;

  localparam int unsigned REG_W          = 5;
  localparam int unsigned DEF_NSTAGE     = 3;
  localparam int unsigned DEF_TW         = 2;
  localparam int unsigned DEF_MUL_CYCLES = 5;
  localparam int unsigned DEF_DIV_CYCLES = 10;
  localparam int unsigned SEL_GRF        = 0;

endpackage

// File: rtl/hazard_scoreboard_if.sv
// D-stage hazard bus: decoded D instruction in, stall/forward/MDU status out.
interface hazard_scoreboard_if
  import hazard_scoreboard_pkg::*;
#(
  parameter int unsigned NSTAGE = DEF_NSTAGE,
  parameter int unsigned TW     = DEF_TW
);
  localparam int unsigned SW = $clog2(NSTAGE + 1);

  logic             d_valid;
  logic [REG_W-1:0] d_rs;
  logic [REG_W-1:0] d_rt;
  logic             d_use_rs;
  logic             d_use_rt;
  logic [TW-1:0]    d_tuse_rs;
  logic [TW-1:0]    d_tuse_rt;
  logic             d_we;
  logic [REG_W-1:0] d_dst;
  logic [TW-1:0]    d_tnew;
  logic             d_md_start;
  logic             d_md_div;
  logic             d_md_use;

  logic             stall;
  logic [SW-1:0]    fwd_rs_sel;
  logic             fwd_rs_ready;
  logic [SW-1:0]    fwd_rt_sel;
  logic             fwd_rt_ready;
  logic             md_busy;

  modport master (
    output d_valid, d_rs, d_rt, d_use_rs, d_use_rt, d_tuse_rs, d_tuse_rt,
           d_we, d_dst, d_tnew, d_md_start, d_md_div, d_md_use,
    input  stall, fwd_rs_sel, fwd_rs_ready, fwd_rt_sel, fwd_rt_ready, md_busy
  );

  modport slave (
    input  d_valid, d_rs, d_rt, d_use_rs, d_use_rt, d_tuse_rs, d_tuse_rt,
           d_we, d_dst, d_tnew, d_md_start, d_md_div, d_md_use,
    output stall, fwd_rs_sel, fwd_rs_ready, fwd_rt_sel, fwd_rt_ready, md_busy
  );

endinterface

// File: rtl/hazard_scoreboard_md_counter.sv
// Multiply/divide busy countdown: loads the operation latency, counts down to idle.
module hs_md_counter
  import hazard_scoreboard_pkg::*;
#(
  parameter int unsigned MUL_CYCLES = DEF_MUL_CYCLES,
  parameter int unsigned DIV_CYCLES = DEF_DIV_CYCLES,
  parameter int unsigned CW         = $clog2(DIV_CYCLES + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic load_i,
  input  logic div_i,
  output logic busy_o
);

  logic [CW-1:0] cnt_q, cnt_d;

  // Next count: a new load takes priority over the running decrement.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = div_i ? CW'(DIV_CYCLES) : CW'(MUL_CYCLES);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  // Counter register; reset abandons any operation in flight.
  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign busy_o = (cnt_q != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// Pipeline hazard scoreboard: per-stage writer records, Tuse/Tnew stall rule, forward select, MDU busy.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int unsigned NSTAGE     = DEF_NSTAGE,
  parameter int unsigned TW         = DEF_TW,
  parameter int unsigned MUL_CYCLES = DEF_MUL_CYCLES,
  parameter int unsigned DIV_CYCLES = DEF_DIV_CYCLES
) (
  input  logic               clk,
  input  logic               reset,
  hazard_scoreboard_if.slave bus
);

  localparam int unsigned SW = $clog2(NSTAGE + 1);

  logic [NSTAGE-1:0]            rec_we_q;
  logic [NSTAGE-1:0][REG_W-1:0] rec_dst_q;
  logic [NSTAGE-1:0][TW-1:0]    rec_tnew_q;

  logic [NSTAGE-1:0] match_rs_c, match_rt_c;
  logic              rs_hit_c, rt_hit_c;
  logic [SW-1:0]     rs_sel_c, rt_sel_c;
  logic [TW-1:0]     rs_tnew_c, rt_tnew_c;
  logic              stall_rs_c, stall_rt_c, stall_md_c, stall_c;
  logic              md_busy_c, md_load_c;

  genvar k;
  generate
    for (k = 0; k < NSTAGE; k++) begin : g_stage
      // Register 0 is hard-wired, so it never matches a writer.
      assign match_rs_c[k] = rec_we_q[k] && (rec_dst_q[k] == bus.d_rs) && (bus.d_rs != '0);
      assign match_rt_c[k] = rec_we_q[k] && (rec_dst_q[k] == bus.d_rt) && (bus.d_rt != '0);

      if (k == 0) begin : g_entry
        // E-stage record: the D instruction enters unless it is stalled or a bubble.
        always_ff @(posedge clk) begin
          if (reset || stall_c || !bus.d_valid) begin
            rec_we_q[0]   <= 1'b0;
            rec_dst_q[0]  <= '0;
            rec_tnew_q[0] <= '0;
          end else begin
            rec_we_q[0]   <= bus.d_we;
            rec_dst_q[0]  <= bus.d_dst;
            rec_tnew_q[0] <= bus.d_tnew;
          end
        end
      end else begin : g_shift
        // Later stages: advance the record, Tnew counts down and saturates at 0.
        always_ff @(posedge clk) begin
          if (reset) begin
            rec_we_q[k]   <= 1'b0;
            rec_dst_q[k]  <= '0;
            rec_tnew_q[k] <= '0;
          end else begin
            rec_we_q[k]   <= rec_we_q[k-1];
            rec_dst_q[k]  <= rec_dst_q[k-1];
            rec_tnew_q[k] <= (rec_tnew_q[k-1] != '0) ? rec_tnew_q[k-1] - TW'(1) : '0;
          end
        end
      end
    end
  endgenerate

  // Priority pick: scan oldest to youngest so the youngest matching writer wins.
  always_comb begin
    rs_hit_c  = 1'b0;
    rs_sel_c  = SW'(SEL_GRF);
    rs_tnew_c = '0;
    rt_hit_c  = 1'b0;
    rt_sel_c  = SW'(SEL_GRF);
    rt_tnew_c = '0;
    for (int i = int'(NSTAGE) - 1; i >= 0; i--) begin
      if (match_rs_c[i]) begin
        rs_hit_c  = 1'b1;
        rs_sel_c  = SW'(i + 1);
        rs_tnew_c = rec_tnew_q[i];
      end
      if (match_rt_c[i]) begin
        rt_hit_c  = 1'b1;
        rt_sel_c  = SW'(i + 1);
        rt_tnew_c = rec_tnew_q[i];
      end
    end
  end

  // Stall when the producer is later than the consumer's need, or the MDU is occupied.
  always_comb begin
    stall_rs_c = bus.d_valid && bus.d_use_rs && rs_hit_c && (rs_tnew_c > bus.d_tuse_rs);
    stall_rt_c = bus.d_valid && bus.d_use_rt && rt_hit_c && (rt_tnew_c > bus.d_tuse_rt);
    stall_md_c = bus.d_valid && bus.d_md_use && md_busy_c;
    stall_c    = stall_rs_c | stall_rt_c | stall_md_c;
    md_load_c  = bus.d_valid && bus.d_md_start && !stall_c;
  end

  hs_md_counter #(
    .MUL_CYCLES (MUL_CYCLES),
    .DIV_CYCLES (DIV_CYCLES)
  ) u_md_counter (
    .clk    (clk),
    .reset  (reset),
    .load_i (md_load_c),
    .div_i  (bus.d_md_div),
    .busy_o (md_busy_c)
  );

  assign bus.stall        = stall_c;
  assign bus.fwd_rs_sel   = rs_sel_c;
  assign bus.fwd_rs_ready = rs_hit_c && (rs_tnew_c == '0);
  assign bus.fwd_rt_sel   = rt_sel_c;
  assign bus.fwd_rt_ready = rt_hit_c && (rt_tnew_c == '0);
  assign bus.md_busy      = md_busy_c;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard bench for hazard_scoreboard: history-based reference model, queued expectations, negedge monitor.
module tb_hazard_scoreboard;
  import hazard_scoreboard_pkg::*;

  localparam int unsigned NST  = 3;
  localparam int unsigned TWL  = 2;
  localparam int unsigned MULC = 5;
  localparam int unsigned DIVC = 10;
  localparam int unsigned SWL  = $clog2(NST + 1);

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  hazard_scoreboard_if #(.NSTAGE(NST), .TW(TWL)) bus ();

  hazard_scoreboard #(
    .NSTAGE(NST), .TW(TWL), .MUL_CYCLES(MULC), .DIV_CYCLES(DIVC)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Instruction that entered E k cycles ago sits at hist[k]; its Tnew has shrunk by k.
  typedef struct { bit we; int dst; int tnew0; } prod_t;
  typedef struct { bit stall; int sel_rs; bit rdy_rs; int sel_rt; bit rdy_rt; bit busy; } exp_t;

  prod_t hist[$];
  exp_t  expq[$];
  int    cyc = 0;
  int    md_free = 0;
  int    total = 0;
  int    bad = 0;

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s cyc=%0d actual=%0d required=%0d", name, cyc, act, req);
    end
  endtask

  function automatic void lookup(input int r, output bit hit, output int sel, output int tn);
    hit = 1'b0; sel = 0; tn = 0;
    if (r == 0) return;
    for (int k = 0; k < hist.size(); k++) begin
      if (hist[k].we && hist[k].dst == r) begin
        hit = 1'b1;
        sel = k + 1;
        tn  = (hist[k].tnew0 > k) ? hist[k].tnew0 - k : 0;
        return;
      end
    end
  endfunction

  task automatic model_reset();
    prod_t b;
    b.we = 1'b0; b.dst = 0; b.tnew0 = 0;
    hist.delete();
    for (int i = 0; i < int'(NST); i++) hist.push_back(b);
    md_free = 0;
  endtask

  task automatic predict(output bit st);
    bit hs, ht, busy;
    int ss, sr, ns, nr;
    exp_t e;
    lookup(int'(bus.d_rs), hs, ss, ns);
    lookup(int'(bus.d_rt), ht, sr, nr);
    busy = (cyc < md_free);
    e.sel_rs = ss; e.rdy_rs = hs && (ns == 0);
    e.sel_rt = sr; e.rdy_rt = ht && (nr == 0);
    e.busy   = busy;
    e.stall  = bus.d_valid && ((bus.d_use_rs && hs && ns > int'(bus.d_tuse_rs)) ||
                               (bus.d_use_rt && ht && nr > int'(bus.d_tuse_rt)) ||
                               (bus.d_md_use && busy));
    expq.push_back(e);
    st = e.stall;
  endtask

  bit last_st = 1'b0;

  // One clock: queue expectation, cross the edge, advance the model.
  task automatic step();
    bit st;
    prod_t p;
    predict(st);
    last_st = st;
    @(posedge clk);
    if (reset) begin
      model_reset();
    end else begin
      p.we = 1'b0; p.dst = 0; p.tnew0 = 0;
      if (bus.d_valid && !st) begin
        p.we = bus.d_we; p.dst = int'(bus.d_dst); p.tnew0 = int'(bus.d_tnew);
      end
      hist.push_front(p);
      void'(hist.pop_back());
      if (bus.d_valid && bus.d_md_start && !st)
        md_free = cyc + 1 + (bus.d_md_div ? int'(DIVC) : int'(MULC));
    end
    cyc++;
    #1;
  endtask

  task automatic drv(input bit v, input int rs, input int rt, input bit urs, input bit urt,
                     input int trs, input int trt, input bit we, input int dst, input int tn,
                     input bit mds, input bit mdd, input bit mdu);
    bus.d_valid    = v;
    bus.d_rs       = 5'(rs);
    bus.d_rt       = 5'(rt);
    bus.d_use_rs   = urs;
    bus.d_use_rt   = urt;
    bus.d_tuse_rs  = TWL'(trs);
    bus.d_tuse_rt  = TWL'(trt);
    bus.d_we       = we;
    bus.d_dst      = 5'(dst);
    bus.d_tnew     = TWL'(tn);
    bus.d_md_start = mds;
    bus.d_md_div   = mdd;
    bus.d_md_use   = mdu;
  endtask

  task automatic nop();
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: every cycle's outputs are compared against the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (expq.size() > 0) begin
        e = expq.pop_front();
        chk("stall",        int'(bus.stall),        int'(e.stall));
        chk("fwd_rs_sel",   int'(bus.fwd_rs_sel),   e.sel_rs);
        chk("fwd_rs_ready", int'(bus.fwd_rs_ready), int'(e.rdy_rs));
        chk("fwd_rt_sel",   int'(bus.fwd_rt_sel),   e.sel_rt);
        chk("fwd_rt_ready", int'(bus.fwd_rt_ready), int'(e.rdy_rt));
        chk("md_busy",      int'(bus.md_busy),      int'(e.busy));
      end
    end
  end

  initial begin
    int n;
    nop();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    reset = 1'b0;

    // Reset state
    #3;
    chk("rst_stall", int'(bus.stall), 0);
    chk("rst_busy",  int'(bus.md_busy), 0);
    step();

    // Load-use: lw $8 (tnew 2) then beq on $8 at tuse 0
    drv(1, 0, 0, 0, 0, 0, 0, 1, 8, 2, 0, 0, 0); step();
    drv(1, 8, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    n = 0;
    for (int i = 0; i < 6; i++) begin
      #3;
      if (!bus.stall) break;
      n++;
      step();
    end
    chk("lu_stall_cycles", n, 2);
    chk("lu_sel",   int'(bus.fwd_rs_sel), 3);
    chk("lu_ready", int'(bus.fwd_rs_ready), 1);
    step(); nop(); step(); step(); step();

    // ALU to ALU: add $9 (tnew 1), sub reads $9 at tuse 1
    drv(1, 0, 0, 0, 0, 0, 0, 1, 9, 1, 0, 0, 0); step();
    drv(1, 9, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    #3;
    chk("alu_stall", int'(bus.stall), 0);
    chk("alu_sel",   int'(bus.fwd_rs_sel), 1);
    chk("alu_ready", int'(bus.fwd_rs_ready), 0);
    step();
    drv(0, 9, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #3;
    chk("alu_next_sel",   int'(bus.fwd_rs_sel), 2);
    chk("alu_next_ready", int'(bus.fwd_rs_ready), 1);
    step(); nop(); step(); step(); step();

    // Register 0 never matches
    drv(1, 0, 0, 0, 0, 0, 0, 1, 0, 2, 0, 0, 0); step();
    drv(1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #3;
    chk("r0_stall", int'(bus.stall), 0);
    chk("r0_sel",   int'(bus.fwd_rs_sel), 0);
    step(); nop(); step(); step(); step();

    // Youngest wins: $5 writers in stage 2 and stage 0
    drv(1, 0, 0, 0, 0, 0, 0, 1, 5, 0, 0, 0, 0); step();
    nop(); step();
    drv(1, 0, 0, 0, 0, 0, 0, 1, 5, 0, 0, 0, 0); step();
    drv(1, 0, 5, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    #3;
    chk("young_sel_rt", int'(bus.fwd_rt_sel), 1);
    step(); nop(); step(); step(); step();

    // Divide then mflo: 10 stall cycles
    drv(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1); step();
    drv(1, 0, 0, 0, 0, 0, 0, 1, 3, 1, 0, 0, 1);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      #3;
      if (!bus.stall) break;
      n++;
      step();
    end
    chk("div_stall_cycles", n, 10);
    step(); nop(); step();

    // Multiply then mflo: 5 stall cycles
    drv(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1); step();
    drv(1, 0, 0, 0, 0, 0, 0, 1, 3, 1, 0, 0, 1);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      #3;
      if (!bus.stall) break;
      n++;
      step();
    end
    chk("mul_stall_cycles", n, 5);
    step(); nop(); step();

    // Non-MDU add while the MDU is busy
    drv(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1); step();
    drv(1, 0, 0, 0, 0, 0, 0, 1, 4, 1, 0, 0, 0);
    #3;
    chk("busy_add_stall", int'(bus.stall), 0);
    chk("busy_add_busy",  int'(bus.md_busy), 1);
    step(); nop(); repeat (6) step();

    // Reset during divide countdown
    drv(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1); step();
    drv(1, 0, 0, 0, 0, 0, 0, 1, 3, 1, 0, 0, 1); step(); step();
    reset = 1'b1; step(); reset = 1'b0;
    #3;
    chk("rst_div_busy",  int'(bus.md_busy), 0);
    chk("rst_div_stall", int'(bus.stall), 0);
    step(); nop(); step();

    // Reset during load-use stall
    drv(1, 0, 0, 0, 0, 0, 0, 1, 8, 2, 0, 0, 0); step();
    drv(1, 8, 8, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0); step();
    reset = 1'b1; step(); reset = 1'b0;
    #3;
    chk("rst_lu_stall",  int'(bus.stall), 0);
    chk("rst_lu_sel_rs", int'(bus.fwd_rs_sel), 0);
    chk("rst_lu_sel_rt", int'(bus.fwd_rt_sel), 0);
    step(); nop(); step();

    // Randomized traffic; a stalled D instruction is usually held, as a real pipeline would
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 199) == 0);
      if (!(last_st && $urandom_range(0, 4) != 0)) begin
        bit mds;
        mds = ($urandom_range(0, 9) == 0);
        drv($urandom_range(0, 7) != 0,
            $urandom_range(0, 7), $urandom_range(0, 7),
            $urandom_range(0, 1), $urandom_range(0, 1),
            $urandom_range(0, 3), $urandom_range(0, 3),
            $urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 3),
            mds, $urandom_range(0, 1),
            mds || ($urandom_range(0, 4) == 0));
      end
      step();
    end
    reset = 1'b0;
    nop();

    @(negedge clk);
    #1;
    chk("queue_drained", expq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
